// File: rtl/cfg_task_sequencer_if.sv
// ---------------------------------------------------------------------------
// cfg_task_sequencer_if
// Bus bundle between the task sequencer and its environment.
//   Read port     : rd_req/rd_addr (out), rd_gnt (in); one rd_valid/rd_data
//                   beat returns for every granted request.
//   Register port : reg_wr_en/reg_wr_addr/reg_wr_data, one word per cycle.
//   Accelerator   : task_start kick pulse (out), task_done completion (in).
// master = sequencer side, slave = memory/accelerator side.
// ---------------------------------------------------------------------------
interface cfg_task_sequencer_if #(
    parameter int ADDR_W = 32
) ();
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic              reg_wr_en;
    logic [7:0]        reg_wr_addr;
    logic [31:0]       reg_wr_data;
    logic              task_start;
    logic              task_done;

    modport master (
        output rd_req, rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data, task_start,
        input  rd_gnt, rd_valid, rd_data, task_done
    );

    modport slave (
        input  rd_req, rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data, task_start,
        output rd_gnt, rd_valid, rd_data, task_done
    );
endinterface

// File: rtl/cfg_task_sequencer.sv
// ---------------------------------------------------------------------------
// cfg_task_sequencer
// Walks a descriptor table of task_num tasks, each REGS_PER_TASK 32-bit
// words. Every word is read from memory and written to the accelerator
// register file; after the last word of a task the accelerator is kicked
// and the sequencer waits for its completion before the next task.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   seq_start       : launch pulse, honoured only when idle
//   cfg_base_addr   : descriptor table byte base, sampled on launch
//   task_num        : number of tasks (0 = none), sampled on launch
//   bus (master)    : read port, register write port, task_start/task_done
//   busy            : sequence in progress
//   seq_done        : one-cycle end-of-sequence pulse
//   task_idx        : index of the task being processed
//   err             : sticky watchdog error
//
// Build option
//   CFG_SEQ_WATCHDOG_EN : when defined, a 24-bit watchdog aborts a task
//   whose completion never arrives and sets err. When undefined, no
//   counter exists, err is tied low and the wait is unbounded.
// ---------------------------------------------------------------------------
module cfg_task_sequencer #(
    parameter int REGS_PER_TASK = 32,
    parameter int ADDR_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 seq_start,
    input  logic [ADDR_W-1:0]    cfg_base_addr,
    input  logic [15:0]          task_num,
    cfg_task_sequencer_if.master bus,
    output logic                 busy,
    output logic                 seq_done,
    output logic [15:0]          task_idx,
    output logic                 err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_WR,
        ST_KICK,
        ST_WAIT,
        ST_NEXT
    } state_t;

    localparam logic [7:0]        LAST_WORD  = 8'(REGS_PER_TASK - 1);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        word_q;
    logic [15:0]       idx_q;
    logic [15:0]       num_q;
    logic [31:0]       data_q;
    logic              rd_req_q;
    logic              wr_en_q;
    logic              task_start_q;
    logic              busy_q;
    logic              seq_done_q;
    logic              last_task;

`ifdef CFG_SEQ_WATCHDOG_EN
    logic [23:0]       wd_q;
    logic              err_q;
`endif

    assign last_task = (idx_q == num_q - 16'd1);

    // addr_q is a running byte pointer: it starts at the base and steps by
    // one word after every register write. Task boundaries are contiguous,
    // so it always equals base + (task_idx*REGS_PER_TASK + w)*4 with natural
    // wrap at 2^ADDR_W, without a multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            word_q       <= '0;
            idx_q        <= '0;
            num_q        <= '0;
            data_q       <= '0;
            rd_req_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            task_start_q <= 1'b0;
            busy_q       <= 1'b0;
            seq_done_q   <= 1'b0;
`ifdef CFG_SEQ_WATCHDOG_EN
            wd_q         <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            wr_en_q      <= 1'b0;
            task_start_q <= 1'b0;
            seq_done_q   <= 1'b0;
`ifdef CFG_SEQ_WATCHDOG_EN
            if (state_q == ST_WAIT) wd_q <= wd_q + 24'd1;
            else                    wd_q <= '0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (seq_start) begin
                        num_q  <= task_num;
                        idx_q  <= '0;
                        word_q <= '0;
                        addr_q <= cfg_base_addr;
`ifdef CFG_SEQ_WATCHDOG_EN
                        err_q  <= 1'b0;
`endif
                        if (task_num != 16'd0) begin
                            state_q  <= ST_REQ;
                            rd_req_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end else begin
                            seq_done_q <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.rd_gnt) begin
                        rd_req_q <= 1'b0;
                        state_q  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bus.rd_valid) begin
                        data_q  <= bus.rd_data;
                        wr_en_q <= 1'b1;
                        state_q <= ST_WR;
                    end
                end
                ST_WR: begin
                    addr_q <= addr_q + WORD_BYTES;
                    if (word_q == LAST_WORD) begin
                        task_start_q <= 1'b1;
                        state_q      <= ST_KICK;
                    end else begin
                        word_q   <= word_q + 8'd1;
                        rd_req_q <= 1'b1;
                        state_q  <= ST_REQ;
                    end
                end
                ST_KICK: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.task_done) begin
                        // seq_done is raised here so it is visible during NEXT
                        seq_done_q <= last_task;
                        state_q    <= ST_NEXT;
                    end
`ifdef CFG_SEQ_WATCHDOG_EN
                    else if (wd_q == 24'hFF_FFFF) begin
                        err_q      <= 1'b1;
                        seq_done_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
`endif
                end
                ST_NEXT: begin
                    if (last_task) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        idx_q    <= idx_q + 16'd1;
                        word_q   <= '0;
                        rd_req_q <= 1'b1;
                        state_q  <= ST_REQ;
                    end
                end
                default: begin
                    rd_req_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_req      = rd_req_q;
    assign bus.rd_addr     = addr_q;
    assign bus.reg_wr_en   = wr_en_q;
    assign bus.reg_wr_addr = word_q;
    assign bus.reg_wr_data = data_q;
    assign bus.task_start  = task_start_q;
    assign busy            = busy_q;
    assign seq_done        = seq_done_q;
    assign task_idx        = idx_q;

`ifdef CFG_SEQ_WATCHDOG_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/cfg_task_sequencer.md
CFG_TASK_SEQUENCER -- requirements
Module: cfg_task_sequencer

Interface
REQ-001 Parameter REGS_PER_TASK, default 32: number of 32-bit config words per task descriptor, 1..256.
REQ-002 Parameter ADDR_W, default 32: byte-address width of the descriptor read port.
REQ-003 Port clk  in  1: single clock; all logic is rising-edge.
REQ-004 Port rst_n  in  1: asynchronous, active-low reset.
REQ-005 Port seq_start  in  1: one-cycle pulse that launches a sequence; it is honoured only in IDLE.
REQ-006 Port cfg_base_addr  in  ADDR_W: descriptor table base address (e.g. 32'h500_0000), sampled on an accepted seq_start.
REQ-007 Port task_num  in  16: number of tasks, sampled on an accepted seq_start; 0 means no task is run.
REQ-008 Port rd_req / rd_addr / rd_gnt  out / out ADDR_W / in: read request; the request is held until rd_gnt is high in the same cycle.
REQ-009 Port rd_valid / rd_data  in / in 32: read return, exactly one beat per granted request.
REQ-010 Port reg_wr_en / reg_wr_addr / reg_wr_data  out 1 / out 8 / out 32: accelerator register write, one cycle per word.
REQ-011 Port task_start  out 1: one-cycle pulse that kicks the accelerator.
REQ-012 Port task_done  in 1: accelerator completion pulse.
REQ-013 Ports busy  out 1, seq_done  out 1 (pulse), task_idx  out 16, err  out 1.

Function
REQ-014 States: IDLE, REQ, DATA, WR, KICK, WAIT, NEXT; encoding is free.
REQ-015 IDLE + seq_start, task_num!=0 -> REQ; word counter w=0; task_idx=0; busy=1 from the next cycle.
REQ-016 IDLE + seq_start, task_num==0 -> seq_done pulses the next cycle; the FSM stays in IDLE.
REQ-017 REQ: rd_req=1, rd_addr = base + (task_idx*REGS_PER_TASK + w)*4, computed mod 2^ADDR_W; on rd_gnt -> DATA.
REQ-018 DATA: on rd_valid capture rd_data -> WR; the FSM waits indefinitely for rd_valid.
REQ-019 WR: reg_wr_en=1 for exactly one cycle, reg_wr_addr=w[7:0], reg_wr_data=captured word.
REQ-019a WR transition: if w==REGS_PER_TASK-1 -> KICK; else w++ -> REQ.
REQ-020 KICK: task_start=1 for one cycle -> WAIT.
REQ-021 WAIT: task_done -> NEXT; task_done seen in any other state is ignored.
REQ-022 NEXT, task_idx==task_num-1: -> IDLE, seq_done pulse in the same cycle, busy drops the cycle after.
REQ-022a NEXT, otherwise: task_idx++, w=0 -> REQ.
REQ-023 Minimum per-word cost is 3 cycles (REQ, DATA, WR) with zero-wait gnt/valid; per-task overhead is KICK + WAIT + NEXT.
REQ-024 seq_start while busy is ignored, with no error flagged.
REQ-025 reg_wr_en, task_start and seq_done are never asserted in the same cycle.

Reset
REQ-026 While rst_n=0 the FSM is IDLE and every output is 0: rd_req, rd_addr, reg_wr_*, task_start, busy, seq_done, task_idx, err.
REQ-027 Reset asserted mid-sequence aborts immediately; outstanding read beats arriving after reset release are ignored in IDLE.

Configuration
REQ-028 Macro CFG_SEQ_WATCHDOG_EN defined: a 24-bit counter runs in WAIT and clears on leaving WAIT.
REQ-028a With CFG_SEQ_WATCHDOG_EN defined, on count 2^24-1 err is set sticky and the FSM goes to IDLE with a seq_done pulse.
REQ-028b With CFG_SEQ_WATCHDOG_EN defined, err clears only on reset or on the next accepted seq_start.
REQ-029 Macro CFG_SEQ_WATCHDOG_EN undefined: no counter is built, err is tied 0, and WAIT waits forever.

Verification
REQ-030 REGS_PER_TASK=4, task_num=1, base=32'h500_0000, gnt/valid zero-wait -> rd_addr 0x5000000..0x500000C; 4 writes to addr 0..3; task_start 12 cycles after start acceptance; seq_done 1 cycle after task_done.
REQ-031 task_num=3 -> task 2 first read at base+0x20; exactly 3 task_start pulses; task_idx=0,1,2.
REQ-032 rd_gnt delayed 5 cycles and rd_valid delayed 7 cycles -> rd_addr stable and rd_req held; no reg_wr_en until valid arrives.
REQ-033 task_num=0 -> no rd_req; seq_done 1 cycle after seq_start; busy stays 0.
REQ-034 rst_n pulled low in WAIT of task 1 of 3 -> all outputs 0 asynchronously; a new seq_start restarts at task 0, word 0.
REQ-035 CFG_SEQ_WATCHDOG_EN defined, task_done withheld -> err=1 and seq_done after 2^24 WAIT cycles; next seq_start clears err.
